tpu_ctrl_unit: RTL and testbench

TPU_CTRL_UNIT -- requirements
Module: tpu_ctrl_unit

---
 rtl/tpu_pkg.sv | 18 +
 rtl/tpu_ctrl_unit.sv | 134 +++++++++++++
 tb/tb_tpu_ctrl_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared state encoding and dimension-width helpers for the TPU control unit
package tpu_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_B,
    S_WAIT_SW,
    S_STREAM_A,
    S_WAIT_C,
    S_STREAM_C,
    S_DRAIN,
    S_ERR
  } state_t;
  localparam int DEF_W = 16;
  function automatic int dim_w(input int w);
    return $clog2(w) + 1;
  endfunction
  localparam int DIM_W = dim_w(DEF_W);
endpackage

// File: rtl/tpu_ctrl_unit.sv
// tpu_ctrl_unit: sequences one matmul command through B load, A stream, bias stream and writeback drain
module tpu_ctrl_unit
  import tpu_pkg::*;
#(
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0]                 cmd_addr_a,
  input  logic [ADDR_WIDTH-1:0]                 cmd_addr_b,
  input  logic [ADDR_WIDTH-1:0]                 cmd_addr_c,
  input  logic [ADDR_WIDTH-1:0]                 cmd_addr_d,
  input  logic [$clog2(SYSTOLIC_ARRAY_WIDTH):0] cmd_m,
  input  logic [$clog2(SYSTOLIC_ARRAY_WIDTH):0] cmd_k,
  input  logic [$clog2(SYSTOLIC_ARRAY_WIDTH):0] cmd_n,
  input  logic [2:0]                            cmd_vpu_mode,
  output logic                                  done,
  input  logic                                  core_writeback_valid,
  output logic [ADDR_WIDTH-1:0]                 ctrl_rd_addr_a,
  output logic                                  ctrl_rd_en_a,
  output logic                                  ctrl_a_valid,
  output logic                                  ctrl_a_switch,
  output logic [ADDR_WIDTH-1:0]                 ctrl_rd_addr_b,
  output logic                                  ctrl_rd_en_b,
  output logic                                  ctrl_b_accept_w,
  output logic [$clog2(SYSTOLIC_ARRAY_WIDTH)-1:0] ctrl_b_weight_index,
  output logic [ADDR_WIDTH-1:0]                 ctrl_rd_addr_c,
  output logic                                  ctrl_rd_en_c,
  output logic                                  ctrl_c_valid,
  output logic [2:0]                            ctrl_vpu_mode,
  output logic [ADDR_WIDTH-1:0]                 ctrl_wr_addr_d,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]       ctrl_row_mask,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]       ctrl_col_mask
);
  localparam int W = SYSTOLIC_ARRAY_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = dim_w(W);
  localparam int IW = $clog2(W);
  localparam int TW = $clog2(4 * W);
  localparam logic [TW-1:0] ONE = TW'(1);
  localparam logic [TW-1:0] TW1 = TW'(W);
  localparam logic [TW-1:0] TW2 = TW'(2 * W);
  state_t state, ns;
  logic [TW-1:0] t, tk, tm;
  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic [DW-1:0] m_q, k_q, n_q, wb_cnt;
  logic [2:0] mode_q;
  logic busy, bad, wb_inc;
  assign tk = TW'(k_q);
  assign tm = TW'(m_q);
  assign busy = state != S_IDLE && state != S_ERR;
  assign bad = cmd_m == '0 || cmd_m > DW'(W) || cmd_k == '0 || cmd_k > DW'(W) ||
               cmd_n == '0 || cmd_n > DW'(W);
  assign wb_inc = busy && core_writeback_valid && wb_cnt != m_q;
  // phase sequencing on the cycle counter; done and ready decoded from state
  always_comb begin
    ns = state;
    done = 1'b0;
    cmd_ready = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) ns = bad ? S_ERR : S_LOAD_B;
      end
      S_LOAD_B:   if (t == tk) ns = (tk == TW1) ? S_STREAM_A : S_WAIT_SW;
      S_WAIT_SW:  if (t == TW1) ns = S_STREAM_A;
      S_STREAM_A: if (t == TW1 + tm) ns = (tm == TW1) ? S_STREAM_C : S_WAIT_C;
      S_WAIT_C:   if (t == TW2) ns = S_STREAM_C;
      S_STREAM_C: if (t == TW2 + tm + ONE) ns = S_DRAIN;
      S_DRAIN: begin
        if (wb_cnt == m_q) begin
          done = 1'b1;
          ns = S_IDLE;
        end
      end
      S_ERR: begin
        done = 1'b1;
        ns = S_IDLE;
      end
      default: ns = S_IDLE;
    endcase
  end
  // per-stream windows decoded from t; overlapping phases (K=W, M=W) are handled here, not by state
  always_comb begin
    ctrl_rd_en_b = busy && t < tk;
    ctrl_rd_addr_b = ctrl_rd_en_b ? addr_b + AW'(k_q) - AW'(t) - AW'(1) : '0;
    ctrl_b_accept_w = busy && t != '0 && t <= tk;
    ctrl_b_weight_index = ctrl_b_accept_w ? IW'(tk - t) : '0;
    ctrl_a_switch = busy && t == TW1;
    ctrl_rd_en_a = busy && t > TW1 && t <= TW1 + tm;
    ctrl_rd_addr_a = ctrl_rd_en_a ? addr_a + AW'(t - TW1 - ONE) : '0;
    ctrl_a_valid = busy && t > TW1 + ONE && t <= TW1 + tm + ONE;
    ctrl_rd_en_c = busy && t > TW2 && t <= TW2 + tm;
    ctrl_rd_addr_c = ctrl_rd_en_c ? addr_c + AW'(t - TW2 - ONE) : '0;
    ctrl_c_valid = busy && t > TW2 + ONE && t <= TW2 + tm + ONE;
    ctrl_vpu_mode = busy ? mode_q : '0;
    ctrl_row_mask = busy ? ~({W{1'b1}} << m_q) : '0;
    ctrl_col_mask = busy ? ~({W{1'b1}} << n_q) : '0;
  end
  // state, cycle counter (frozen in DRAIN), latched command and writeback tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      t <= '0;
      addr_a <= '0;
      addr_b <= '0;
      addr_c <= '0;
      m_q <= '0;
      k_q <= '0;
      n_q <= '0;
      mode_q <= '0;
      wb_cnt <= '0;
      ctrl_wr_addr_d <= '0;
    end else begin
      state <= ns;
      t <= (state == S_IDLE) ? '0 : (state == S_DRAIN || state == S_ERR) ? t : t + ONE;
      if (state == S_IDLE && cmd_valid) begin
        addr_a <= cmd_addr_a;
        addr_b <= cmd_addr_b;
        addr_c <= cmd_addr_c;
        m_q <= cmd_m;
        k_q <= cmd_k;
        n_q <= cmd_n;
        mode_q <= cmd_vpu_mode;
      end
      wb_cnt <= (state == S_IDLE) ? '0 : wb_cnt + DW'(wb_inc);
      ctrl_wr_addr_d <= (state == S_IDLE) ? ((cmd_valid && !bad) ? cmd_addr_d : '0) :
                        done ? '0 : ctrl_wr_addr_d + AW'(wb_inc);
    end
  end
endmodule

// File: tb/tb_tpu_ctrl_unit.sv
// tb_tpu_ctrl_unit: directed vector bench for the TPU control unit
module tb_tpu_ctrl_unit;
  import tpu_pkg::*;
  localparam int W = 16;
  localparam int AW = 10;
  localparam int F_EN_B = 0, F_ADDR_B = 1, F_ACC = 2, F_WIDX = 3, F_SW = 4, F_EN_A = 5,
                 F_ADDR_A = 6, F_AV = 7, F_EN_C = 8, F_ADDR_C = 9, F_CV = 10, F_WRD = 11,
                 F_RMASK = 12, F_CMASK = 13, F_DONE = 14, F_READY = 15, F_VPU = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic core_writeback_valid = 1'b0;
  logic [AW-1:0] cmd_addr_a = '0, cmd_addr_b = '0, cmd_addr_c = '0, cmd_addr_d = '0;
  logic [DIM_W-1:0] cmd_m = '0, cmd_k = '0, cmd_n = '0;
  logic [2:0] cmd_vpu_mode = '0;
  logic cmd_ready, done, ctrl_rd_en_a, ctrl_a_valid, ctrl_a_switch, ctrl_rd_en_b, ctrl_b_accept_w;
  logic ctrl_rd_en_c, ctrl_c_valid;
  logic [AW-1:0] ctrl_rd_addr_a, ctrl_rd_addr_b, ctrl_rd_addr_c, ctrl_wr_addr_d;
  logic [3:0] ctrl_b_weight_index;
  logic [2:0] ctrl_vpu_mode;
  logic [W-1:0] ctrl_row_mask, ctrl_col_mask;
  int checks = 0;
  int failures = 0;
  typedef struct packed {
    logic ready, done, en_b, acc, sw, en_a, a_valid, en_c, c_valid;
    logic [3:0] widx;
    logic [2:0] vpu;
    logic [AW-1:0] addr_b, addr_a, addr_c, wr_d;
    logic [W-1:0] rmask, cmask;
  } obs_t;
  typedef struct {
    int sc;
    int t;
    int f;
    int v;
  } vec_t;
  vec_t tab[$];
  obs_t cap[64];
  obs_t idle;
  string fname[17] = '{"en_b", "addr_b", "accept_w", "weight_index", "a_switch", "en_a",
                       "addr_a", "a_valid", "en_c", "addr_c", "c_valid", "wr_addr_d",
                       "row_mask", "col_mask", "done", "cmd_ready", "vpu_mode"};

  tpu_ctrl_unit #(.SYSTOLIC_ARRAY_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_c(cmd_addr_c),
    .cmd_addr_d(cmd_addr_d), .cmd_m(cmd_m), .cmd_k(cmd_k), .cmd_n(cmd_n),
    .cmd_vpu_mode(cmd_vpu_mode), .done(done), .core_writeback_valid(core_writeback_valid),
    .ctrl_rd_addr_a(ctrl_rd_addr_a), .ctrl_rd_en_a(ctrl_rd_en_a), .ctrl_a_valid(ctrl_a_valid),
    .ctrl_a_switch(ctrl_a_switch), .ctrl_rd_addr_b(ctrl_rd_addr_b), .ctrl_rd_en_b(ctrl_rd_en_b),
    .ctrl_b_accept_w(ctrl_b_accept_w), .ctrl_b_weight_index(ctrl_b_weight_index),
    .ctrl_rd_addr_c(ctrl_rd_addr_c), .ctrl_rd_en_c(ctrl_rd_en_c), .ctrl_c_valid(ctrl_c_valid),
    .ctrl_vpu_mode(ctrl_vpu_mode), .ctrl_wr_addr_d(ctrl_wr_addr_d),
    .ctrl_row_mask(ctrl_row_mask), .ctrl_col_mask(ctrl_col_mask)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.ready = cmd_ready;
    o.done = done;
    o.en_b = ctrl_rd_en_b;
    o.acc = ctrl_b_accept_w;
    o.sw = ctrl_a_switch;
    o.en_a = ctrl_rd_en_a;
    o.a_valid = ctrl_a_valid;
    o.en_c = ctrl_rd_en_c;
    o.c_valid = ctrl_c_valid;
    o.widx = ctrl_b_weight_index;
    o.vpu = ctrl_vpu_mode;
    o.addr_b = ctrl_rd_addr_b;
    o.addr_a = ctrl_rd_addr_a;
    o.addr_c = ctrl_rd_addr_c;
    o.wr_d = ctrl_wr_addr_d;
    o.rmask = ctrl_row_mask;
    o.cmask = ctrl_col_mask;
    return o;
  endfunction

  function automatic obs_t model(input int t, wbc, m, k, n, a, b, c, d, mode);
    obs_t e;
    e = '0;
    e.en_b = t < k;
    e.addr_b = e.en_b ? AW'(b + k - 1 - t) : '0;
    e.acc = t >= 1 && t <= k;
    e.widx = e.acc ? 4'(k - t) : '0;
    e.sw = t == W;
    e.en_a = t >= W + 1 && t <= W + m;
    e.addr_a = e.en_a ? AW'(a + t - W - 1) : '0;
    e.a_valid = t >= W + 2 && t <= W + m + 1;
    e.en_c = t >= 2 * W + 1 && t <= 2 * W + m;
    e.addr_c = e.en_c ? AW'(c + t - 2 * W - 1) : '0;
    e.c_valid = t >= 2 * W + 2 && t <= 2 * W + m + 1;
    e.wr_d = AW'(d + wbc);
    e.rmask = W'((1 << m) - 1);
    e.cmask = W'((1 << n) - 1);
    e.vpu = 3'(mode);
    e.done = t >= 2 * W + m + 2 && wbc == m;
    return e;
  endfunction

  function automatic int fget(input obs_t o, input int f);
    case (f)
      F_EN_B:   return int'(o.en_b);
      F_ADDR_B: return int'(o.addr_b);
      F_ACC:    return int'(o.acc);
      F_WIDX:   return int'(o.widx);
      F_SW:     return int'(o.sw);
      F_EN_A:   return int'(o.en_a);
      F_ADDR_A: return int'(o.addr_a);
      F_AV:     return int'(o.a_valid);
      F_EN_C:   return int'(o.en_c);
      F_ADDR_C: return int'(o.addr_c);
      F_CV:     return int'(o.c_valid);
      F_WRD:    return int'(o.wr_d);
      F_RMASK:  return int'(o.rmask);
      F_CMASK:  return int'(o.cmask);
      F_DONE:   return int'(o.done);
      F_READY:  return int'(o.ready);
      F_VPU:    return int'(o.vpu);
      default:  return -1;
    endcase
  endfunction

  task automatic chk_obs(input string nm, input int t, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h exp=%h", nm, t, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int t, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0d exp=%0d", nm, t, act, exp);
    end
  endtask

  task automatic offer(input int m, k, n, a, b, c, d, mode);
    @(negedge clk);
    cmd_m = DIM_W'(m);
    cmd_k = DIM_W'(k);
    cmd_n = DIM_W'(n);
    cmd_addr_a = AW'(a);
    cmd_addr_b = AW'(b);
    cmd_addr_c = AW'(c);
    cmd_addr_d = AW'(d);
    cmd_vpu_mode = 3'(mode);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int sc, m, k, n, a, b, c, d, mode, wb0, nwb, rst_t);
    obs_t o, e;
    int wbc;
    wbc = 0;
    offer(m, k, n, a, b, c, d, mode);
    for (int t = 0; t < 120; t++) begin
      if (t > 0) @(negedge clk);
      o = sample();
      if (t < 64) cap[t] = o;
      e = model(t, wbc, m, k, n, a, b, c, d, mode);
      chk_obs($sformatf("sc%0d_cycle", sc), t, o, e);
      if (e.done) break;
      if (t == rst_t) begin
        rst = 1'b1;
        break;
      end
      core_writeback_valid = t >= wb0 && t < wb0 + nwb;
      if (core_writeback_valid && wbc < m) wbc++;
    end
    core_writeback_valid = 1'b0;
    @(negedge clk);
    chk_obs($sformatf("sc%0d_idle_after", sc), -1, sample(), idle);
    rst = 1'b0;
    foreach (tab[i])
      if (tab[i].sc == sc)
        chk_int($sformatf("sc%0d_%s", sc, fname[tab[i].f]), tab[i].t,
                fget(cap[tab[i].t], tab[i].f), tab[i].v);
  endtask

  task automatic run_bad(input int m, k, n);
    obs_t o;
    offer(m, k, n, 7, 7, 7, 7, 1);
    o = sample();
    chk_int($sformatf("bad_m%0d_k%0d_n%0d_strobes", m, k, n), 0,
            int'({o.ready, o.done, o.en_b, o.acc, o.sw, o.en_a, o.a_valid, o.en_c, o.c_valid}), 128);
    chk_int($sformatf("bad_m%0d_k%0d_n%0d_addrs", m, k, n), 0,
            int'({o.addr_a, o.addr_b, o.addr_c}), 0);
    @(negedge clk);
    chk_obs($sformatf("bad_m%0d_k%0d_n%0d_idle", m, k, n), 1, sample(), idle);
  endtask

  initial begin
    int bad_m[3] = '{2, 17, 2};
    int bad_k[3] = '{0, 2, 2};
    int bad_n[3] = '{2, 2, 0};
    idle = '0;
    idle.ready = 1'b1;
    tab.push_back('{1, 0, F_ADDR_B, 11});  tab.push_back('{1, 1, F_ADDR_B, 10});
    tab.push_back('{1, 0, F_EN_B, 1});     tab.push_back('{1, 2, F_EN_B, 0});
    tab.push_back('{1, 1, F_WIDX, 1});     tab.push_back('{1, 2, F_WIDX, 0});
    tab.push_back('{1, 0, F_ACC, 0});      tab.push_back('{1, 2, F_ACC, 1});
    tab.push_back('{1, 3, F_ACC, 0});      tab.push_back('{1, 15, F_SW, 0});
    tab.push_back('{1, 16, F_SW, 1});      tab.push_back('{1, 17, F_SW, 0});
    tab.push_back('{1, 0, F_RMASK, 3});    tab.push_back('{1, 0, F_CMASK, 3});
    tab.push_back('{1, 38, F_RMASK, 3});   tab.push_back('{1, 0, F_VPU, 5});
    tab.push_back('{1, 17, F_EN_A, 1});    tab.push_back('{1, 17, F_ADDR_A, 0});
    tab.push_back('{1, 18, F_ADDR_A, 1});  tab.push_back('{1, 19, F_EN_A, 0});
    tab.push_back('{1, 17, F_AV, 0});      tab.push_back('{1, 18, F_AV, 1});
    tab.push_back('{1, 19, F_AV, 1});      tab.push_back('{1, 20, F_AV, 0});
    tab.push_back('{1, 33, F_ADDR_C, 20}); tab.push_back('{1, 34, F_ADDR_C, 21});
    tab.push_back('{1, 35, F_EN_C, 0});    tab.push_back('{1, 33, F_CV, 0});
    tab.push_back('{1, 34, F_CV, 1});      tab.push_back('{1, 35, F_CV, 1});
    tab.push_back('{1, 36, F_CV, 0});      tab.push_back('{1, 36, F_WRD, 0});
    tab.push_back('{1, 37, F_WRD, 1});     tab.push_back('{1, 37, F_DONE, 0});
    tab.push_back('{1, 38, F_DONE, 1});    tab.push_back('{1, 38, F_READY, 0});
    tab.push_back('{2, 0, F_ADDR_B, 11});  tab.push_back('{2, 11, F_ADDR_B, 0});
    tab.push_back('{2, 12, F_ADDR_B, 1023}); tab.push_back('{2, 15, F_ADDR_B, 1020});
    tab.push_back('{2, 16, F_EN_B, 0});    tab.push_back('{2, 1, F_WIDX, 15});
    tab.push_back('{2, 16, F_WIDX, 0});    tab.push_back('{2, 16, F_SW, 1});
    tab.push_back('{2, 16, F_ACC, 1});     tab.push_back('{2, 0, F_RMASK, 65535});
    tab.push_back('{2, 0, F_CMASK, 65535}); tab.push_back('{2, 17, F_ADDR_A, 1015});
    tab.push_back('{2, 26, F_ADDR_A, 0});  tab.push_back('{2, 32, F_ADDR_A, 6});
    tab.push_back('{2, 33, F_AV, 1});      tab.push_back('{2, 33, F_EN_C, 1});
    tab.push_back('{2, 48, F_ADDR_C, 20}); tab.push_back('{2, 49, F_CV, 1});
    tab.push_back('{2, 50, F_CV, 0});      tab.push_back('{2, 26, F_WRD, 12});
    tab.push_back('{2, 50, F_DONE, 1});
    tab.push_back('{4, 0, F_ADDR_B, 200}); tab.push_back('{4, 1, F_EN_B, 0});
    tab.push_back('{4, 1, F_ACC, 1});      tab.push_back('{4, 1, F_WIDX, 0});
    tab.push_back('{4, 0, F_RMASK, 7});    tab.push_back('{4, 0, F_CMASK, 15});
    tab.push_back('{4, 10, F_WRD, 503});   tab.push_back('{4, 36, F_DONE, 0});
    tab.push_back('{4, 37, F_DONE, 1});    tab.push_back('{4, 0, F_VPU, 7});
    repeat (2) @(negedge clk);
    chk_obs("reset_state", 0, sample(), idle);
    rst = 1'b0;
    run_cmd(1, 2, 2, 2, 0, 10, 20, 0, 5, 36, 2, -1);
    run_cmd(2, 16, 16, 16, 1015, 1020, 5, 1020, 3, 10, 16, -1);
    for (int i = 0; i < 3; i++) run_bad(bad_m[i], bad_k[i], bad_n[i]);
    run_cmd(3, 3, 3, 3, 50, 60, 70, 80, 2, 36, 3, 20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_obs("idle_writeback_ignored", i, sample(), idle);
      core_writeback_valid = 1'b1;
    end
    @(negedge clk);
    chk_obs("idle_writeback_ignored", 3, sample(), idle);
    core_writeback_valid = 1'b0;
    run_cmd(4, 3, 1, 4, 100, 200, 300, 500, 7, 5, 5, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
